alu_ctrl_mc: RTL and testbench
==============================

Name: alu_ctrl_mc

Overview:
Parametrised successor to the combinational ALU control decode. It produces the ALU control word from ALUOp/funct and adds multi-cycle sequencing for MULT/DIV. The block holds the PC with a stall until the multiply/divide latency elapses, then issues a single HI/LO write strobe. It sits between the main control unit and the datapath (ALU, HI/LO register pair, PC enable) of the MIPS core.

Parameters:
CTRL_W, 4, ALU control word width; must be >=4; encodings below are zero-extended on the MSB side.
MULT_CYCLES, 4, busy cycles for MULT/MULTU; must be >=1.
DIV_CYCLES, 32, busy cycles for DIV/DIVU; must be >=1.
CNT_W, 6, counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
valid_in  input  1  current instruction is valid
ALUOp  input  2  from main control
funct  input  6  instruction funct field
alu_ctrl  output  CTRL_W  ALU control word, combinational
illegal  output  1  ALUOp=10 with an unsupported funct, combinational
hilo_sel  output  1  1 = MFHI, 0 = MFLO, combinational
stall  output  1  hold PC and register-file write
busy  output  1  multiply/divide unit is occupied
md_op  output  2  latched op: 00=MULT 01=MULTU 10=DIV 11=DIVU
hilo_we  output  1  one-cycle HI/LO write strobe

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset. It is sampled on the rising clk edge.
- Encodings (4-bit): AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, NOR=1100, XOR=0011.
- ALUOp decode: 00 gives ADD, 01 gives SUB, 11 gives OR. For these, illegal=0.
- ALUOp=10 decodes funct:
  - 100000/100001 give ADD; 100010/100011 give SUB; 100100 gives AND; 100101 gives OR; 100110 gives XOR; 100111 gives NOR; 101010/101011 give SLT.
  - 011000/011001/011010/011011 (MULT/MULTU/DIV/DIVU, the md class) give ADD.
  - 010000 (MFHI) and 010010 (MFLO) give ADD. hilo_sel = funct[1]==0.
  - Any other funct gives ADD with illegal=1.
- alu_ctrl, illegal and hilo_sel are purely combinational from the inputs and ignore the FSM state.
- FSM states IDLE, BUSY, DONE. Reset state is IDLE. Registered values reset to: md_op=00, hilo_we=0, counter=0.
- IDLE:
  - Accept condition: valid_in & ALUOp==10 & md class.
  - stall = accept, combinationally.
  - On accept: md_op <= {funct[1],funct[0]}; counter <= (MULT_CYCLES or DIV_CYCLES) - 1; next state BUSY.
- BUSY:
  - stall=1, busy=1.
  - If counter==0, go to DONE; otherwise decrement the counter.
  - Inputs are ignored, because the stalled instruction is held on them.
- DONE (exactly one cycle):
  - stall=0, busy=1, hilo_we=1 (registered: set on the BUSY to DONE edge, cleared on exit).
  - The md instruction retires in this cycle. Inputs are ignored, so the still-present MULT/DIV does not retrigger.
  - Next state IDLE.
- Latency: the accept cycle plus N BUSY cycles gives N+1 stall cycles. hilo_we is high in cycle N+1, counting the accept cycle as cycle 0.
- MFHI/MFLO arriving in IDLE: no stall. Back-to-back md ops: the second is accepted in the first IDLE cycle after DONE.
- reset has priority over all transitions. Reset asserted mid-BUSY or in DONE: next cycle IDLE, stall=0, busy=0, hilo_we=0, no write strobe issued.
- valid_in=0 in IDLE: no accept, stall=0, whatever the ALUOp/funct values.

Test Plan:
- Combinational sweep: ALUOp=00 gives 0010; 01 gives 0110; 11 gives 0001. ALUOp=10 with funct 100100/100101/100110/100111/101010 gives 0000/0001/0011/1100/0111. funct=111111 gives illegal=1, alu_ctrl=0010.
- MULT timing (MULT_CYCLES=4): ALUOp=10, funct=011000, valid_in=1 at cycle 0. Stall is high in cycles 0-4 and low in cycle 5. hilo_we=1 only in cycle 5. md_op=00. busy is high in cycles 1-5.
- DIVU timing (DIV_CYCLES=32): funct=011011. Stall lasts 33 cycles, hilo_we pulses once at cycle 33, md_op=11. Inputs stay held through DONE with no retrigger: IDLE at cycle 34, stall=0.
- Back-to-back: MULT then DIV, each held until retired. The DIV is accepted in the cycle after the MULT's DONE. Exactly two hilo_we pulses, separated by 33 cycles.
- Reset mid-op: assert reset in BUSY cycle 2 of a MULT. Next cycle stall=0, busy=0, hilo_we=0, and no hilo_we appears later.
- MFHI/MFLO and gating: funct=010000 gives hilo_sel=1 with no stall; 010010 gives hilo_sel=0. A md-class funct with valid_in=0 gives no stall and no state change.

Source files
------------

// File: rtl/alu_ctrl_mc.sv
// ALU control decode with multi-cycle MULT/DIV sequencing: stalls the PC for the
// unit latency, then issues a single HI/LO write strobe.
module alu_ctrl_mc #(
    parameter int CTRL_W      = 4,
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [1:0]        ALUOp,
    input  logic [5:0]        funct,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              illegal,
    output logic              hilo_sel,
    output logic              stall,
    output logic              busy,
    output logic [1:0]        md_op,
    output logic              hilo_we
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic [3:0]       ctrl4;
    logic             md_class;
    logic             accept;

    always_comb begin
        ctrl4   = ALU_ADD;
        illegal = 1'b0;
        case (ALUOp)
            2'b00: ctrl4 = ALU_ADD;
            2'b01: ctrl4 = ALU_SUB;
            2'b11: ctrl4 = ALU_OR;
            default: begin
                case (funct)
                    6'b100000, 6'b100001: ctrl4 = ALU_ADD;
                    6'b100010, 6'b100011: ctrl4 = ALU_SUB;
                    6'b100100:            ctrl4 = ALU_AND;
                    6'b100101:            ctrl4 = ALU_OR;
                    6'b100110:            ctrl4 = ALU_XOR;
                    6'b100111:            ctrl4 = ALU_NOR;
                    6'b101010, 6'b101011: ctrl4 = ALU_SLT;
                    // md class and MFHI/MFLO route the adder; the result is unused
                    6'b011000, 6'b011001, 6'b011010, 6'b011011,
                    6'b010000, 6'b010010: ctrl4 = ALU_ADD;
                    default: begin
                        ctrl4   = ALU_ADD;
                        illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

    assign alu_ctrl = CTRL_W'(ctrl4);
    assign hilo_sel = ~funct[1];

    // Handshake: an md instruction is taken when valid_in is high in IDLE; the
    // issuer must hold it on the inputs while stall is high and it retires in DONE.
    assign md_class = (funct[5:2] == 4'b0110);
    assign accept   = (state == IDLE) && valid_in && (ALUOp == 2'b10) && md_class;
    assign stall    = accept || (state == BUSY);
    assign busy     = (state == BUSY) || (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            md_op   <= 2'b00;
            hilo_we <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    hilo_we <= 1'b0;
                    if (accept) begin
                        md_op <= funct[1:0];
                        count <= funct[1] ? DIV_LOAD : MULT_LOAD;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (count == '0) begin
                        state   <= DONE;
                        hilo_we <= 1'b1;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    hilo_we <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    hilo_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl_mc.sv
// Bench for alu_ctrl_mc: cycle-level timeline model for md ops plus a table model
// of the decode; HI/LO strobes are checked by a queue-driven monitor.
module tb_alu_ctrl_mc;

    localparam int MULT_N = 4;
    localparam int DIV_N  = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_in;
    logic [1:0] ALUOp;
    logic [5:0] funct;
    logic [3:0] alu_ctrl;
    logic       illegal;
    logic       hilo_sel;
    logic       stall;
    logic       busy;
    logic [1:0] md_op;
    logic       hilo_we;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Expected strobe: {cycle index of hilo_we, md_op}
    logic [33:0] exp_q[$];
    logic [33:0] mon_e;

    alu_ctrl_mc #(
        .CTRL_W(4), .MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(6)
    ) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ALUOp(ALUOp),
        .funct(funct), .alu_ctrl(alu_ctrl), .illegal(illegal),
        .hilo_sel(hilo_sel), .stall(stall), .busy(busy), .md_op(md_op),
        .hilo_we(hilo_we)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // {illegal, hilo_sel, ctrl} straight from the instruction table
    function automatic logic [5:0] ref_decode(input logic [1:0] op, input logic [5:0] f);
        logic [3:0] c;
        logic       ill;
        ill = 1'b0;
        if (op == 2'b00)      c = 4'b0010;
        else if (op == 2'b01) c = 4'b0110;
        else if (op == 2'b11) c = 4'b0001;
        else begin
            case (f)
                6'h20, 6'h21: c = 4'b0010;
                6'h22, 6'h23: c = 4'b0110;
                6'h24:        c = 4'b0000;
                6'h25:        c = 4'b0001;
                6'h26:        c = 4'b0011;
                6'h27:        c = 4'b1100;
                6'h2a, 6'h2b: c = 4'b0111;
                6'h18, 6'h19, 6'h1a, 6'h1b, 6'h10, 6'h12: c = 4'b0010;
                default: begin c = 4'b0010; ill = 1'b1; end
            endcase
        end
        return {ill, ~f[1], c};
    endfunction

    // HI/LO strobe monitor
    always @(negedge clk) begin
        if (!reset && hilo_we) begin
            if (exp_q.size() == 0) begin
                chk("hilo_we_spurious", 32'(hilo_we), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("hilo_we_cycle", 32'(cyc), 32'(mon_e[33:2]));
                chk("md_op", 32'(md_op), 32'(mon_e[1:0]));
            end
        end
    end

    // One cycle with no accept expected: decode checked, no stall, unit idle
    task automatic idle_cycle(input logic v, input logic [1:0] op, input logic [5:0] f);
        logic [5:0] e;
        @(posedge clk); #1;
        valid_in = v; ALUOp = op; funct = f;
        e = ref_decode(op, f);
        @(negedge clk);
        chk("alu_ctrl", 32'(alu_ctrl), 32'(e[3:0]));
        chk("illegal", 32'(illegal), 32'(e[5]));
        chk("hilo_sel", 32'(hilo_sel), 32'(e[4]));
        chk("idle_stall", 32'(stall), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    // Issue an md op, hold it through DONE, check the stall/busy timeline
    task automatic run_md(input logic [5:0] f);
        int n;
        n = f[1] ? DIV_N : MULT_N;
        @(posedge clk); #1;
        valid_in = 1'b1; ALUOp = 2'b10; funct = f;
        exp_q.push_back({32'(cyc + n + 1), f[1:0]});
        for (int i = 0; i <= n + 1; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            @(negedge clk);
            chk("md_stall", 32'(stall), 32'(i <= n));
            chk("md_busy", 32'(busy), 32'(i >= 1));
        end
    endtask

    task automatic random_idle();
        logic       v;
        logic [1:0] op;
        logic [5:0] f;
        v  = 1'($urandom_range(0, 1));
        op = 2'($urandom_range(0, 3));
        f  = 6'($urandom_range(0, 63));
        if ($urandom_range(0, 1) == 1) f = 6'h20 + 6'($urandom_range(0, 11));
        if (v && op == 2'b10 && f[5:2] == 4'b0110) v = 1'b0;
        idle_cycle(v, op, f);
    endtask

    logic [5:0] md_tab [4];

    initial begin
        md_tab[0] = 6'h18; md_tab[1] = 6'h19; md_tab[2] = 6'h1a; md_tab[3] = 6'h1b;
        reset = 1'b1; valid_in = 1'b0; ALUOp = 2'b00; funct = 6'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hilo_we", 32'(hilo_we), 32'd0);
        chk("rst_md_op", 32'(md_op), 32'd0);
        reset = 1'b0;

        // Directed decode sweep
        idle_cycle(1'b1, 2'b00, 6'h3f);
        idle_cycle(1'b1, 2'b01, 6'h18);
        idle_cycle(1'b1, 2'b11, 6'h00);
        idle_cycle(1'b1, 2'b10, 6'h24);
        idle_cycle(1'b1, 2'b10, 6'h25);
        idle_cycle(1'b1, 2'b10, 6'h26);
        idle_cycle(1'b1, 2'b10, 6'h27);
        idle_cycle(1'b1, 2'b10, 6'h2a);
        idle_cycle(1'b1, 2'b10, 6'h3f);
        idle_cycle(1'b1, 2'b10, 6'h10);
        idle_cycle(1'b1, 2'b10, 6'h12);
        // md class without valid_in: no accept
        idle_cycle(1'b0, 2'b10, 6'h18);
        idle_cycle(1'b0, 2'b10, 6'h1b);
        repeat (40) random_idle();

        // MULT, DIVU, back-to-back MULT then DIV
        run_md(6'h18);
        idle_cycle(1'b0, 2'b00, 6'h00);
        run_md(6'h1b);
        idle_cycle(1'b0, 2'b10, 6'h1b);
        run_md(6'h18);
        run_md(6'h1a);
        idle_cycle(1'b0, 2'b00, 6'h00);

        // Reset in the second BUSY cycle of a MULT
        @(posedge clk); #1;
        valid_in = 1'b1; ALUOp = 2'b10; funct = 6'h18;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; valid_in = 1'b0;
        @(negedge clk);
        chk("rstmid_stall", 32'(stall), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_hilo_we", 32'(hilo_we), 32'd0);
        repeat (8) idle_cycle(1'b0, 2'b10, 6'h18);

        // Random md ops interleaved with non-accepting traffic
        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(0, 3)) random_idle();
            run_md(md_tab[$urandom_range(0, 3)]);
        end
        repeat (4) idle_cycle(1'b0, 2'b00, 6'h00);

        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
